// File: rtl/insn_decode_stage.sv
// Decode stage: classifies a fetched instruction into a one-hot CODE bus and
// presents it through a 2-entry skid buffer with a registered IN_READY.
module insn_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [XLEN-1:0] IN_INSN,
    input  logic [XLEN-1:0] IN_PC,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] INSN,
    output logic [XLEN-1:0] PC,
    output logic [9:0]      CODE,
    output logic [2:0]      FUNC3,
    output logic            USE_IMM,
    output logic            ILLEGAL
);

    typedef struct packed {
        logic [XLEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic [9:0]      code;
        logic [2:0]      func3;
        logic            use_imm;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    // Every legal opcode ends in 2'b11, so an exact 7-bit match also
    // rejects compressed/invalid low bits.
    function automatic entry_t decode(input logic [XLEN-1:0] insn, input logic [XLEN-1:0] pc);
        entry_t e;
        e.insn    = insn;
        e.pc      = pc;
        e.code    = '0;
        e.func3   = insn[14:12];
        e.use_imm = 1'b0;
        e.illegal = 1'b0;
        case (insn[6:0])
            7'b0110111: e.code[0] = 1'b1;
            7'b0010111: e.code[1] = 1'b1;
            7'b0010011: begin
                e.code[2]  = 1'b1;
                e.use_imm  = 1'b1;
            end
            7'b0110011: e.code[2] = 1'b1;
            7'b1101111: e.code[3] = 1'b1;
            7'b1100111: e.code[4] = 1'b1;
            7'b1100011: e.code[5] = 1'b1;
            7'b0001111: e.code[6] = 1'b1;
            7'b0000011: e.code[7] = 1'b1;
            7'b1110011: e.code[8] = 1'b1;
            7'b0100011: e.code[9] = 1'b1;
            default:    e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    state_t state_q, state_d;
    entry_t main_q, skid_q, in_dec;
    logic   accept, consume;
    logic   load_main, load_skid, main_from_skid, in_ready_d;

    assign in_dec  = decode(IN_INSN, IN_PC);
    assign accept  = IN_VALID & IN_READY;
    assign consume = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= EMPTY;
            IN_READY <= 1'b1;
        end else begin
            state_q  <= state_d;
            IN_READY <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (FLUSH) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !consume)      state_d = FULL;
                    else if (!accept && consume) state_d = EMPTY;
                end
                FULL:    if (consume) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready_d     = (state_d != FULL);
        main_from_skid = (state_q == FULL);
        load_skid      = !FLUSH && (state_q == ONE) && accept && !consume;
        load_main      = !FLUSH && (((state_q == EMPTY) && accept) ||
                                    ((state_q == ONE) && accept && consume) ||
                                    ((state_q == FULL) && consume));
    end

    // Data is reset too so that all outputs read zero straight out of reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) main_q <= main_from_skid ? skid_q : in_dec;
            if (load_skid) skid_q <= in_dec;
        end
    end

    assign OUT_VALID = (state_q != EMPTY);
    assign INSN      = main_q.insn;
    assign PC        = main_q.pc;
    assign CODE      = main_q.code;
    assign FUNC3     = main_q.func3;
    assign USE_IMM   = main_q.use_imm;
    assign ILLEGAL   = main_q.illegal;

endmodule
